// File: rtl/training_control_fsm_pkg.sv
// Shared types and default constants for the training-phase controller, also used by the
// optimiser datapath and debug logic.
package training_control_fsm_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StAdam      = 2'd1,
    StManhattan = 2'd2,
    StDone      = 2'd3
  } train_state_e;

  localparam int unsigned DefErrW         = 34;
  localparam logic [33:0] DefSwitchThresh = 34'd1024;
  localparam logic [33:0] DefDoneThresh   = 34'd4;
  localparam int unsigned DefMaxIter      = 1000;
  localparam int unsigned DefIterW        = 16;

endpackage

// File: rtl/training_control_fsm_if.sv
// Request/status bundle between the training loop sequencer and the training controller.
interface training_control_fsm_if #(
  parameter int unsigned ERR_W = 34
);

  logic             training_mode;
  logic [ERR_W-1:0] SQUARED_ERROR;
  logic             training_done;
  logic             adam_signal;
  logic             manhatten_signal;

  modport master (
    output training_mode,
    output SQUARED_ERROR,
    input  training_done,
    input  adam_signal,
    input  manhatten_signal
  );

  modport slave (
    input  training_mode,
    input  SQUARED_ERROR,
    output training_done,
    output adam_signal,
    output manhatten_signal
  );

endinterface

// File: rtl/training_control_fsm_iter_counter.sv
// Iteration counter for the active training phases; flags the last allowed iteration.
module training_iter_counter #(
  parameter int unsigned ITER_W   = 16,
  parameter int unsigned MAX_ITER = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [ITER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + ITER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == ITER_W'(MAX_ITER - 1));

endmodule

// File: rtl/training_control_fsm.sv
// Training-phase controller: Adam for coarse descent, then sign-based Manhattan updates,
// finishing on the error target or the iteration cap. Moore outputs, one-hot or idle.
module training_control_fsm
  import training_control_fsm_pkg::*;
#(
  parameter int unsigned      ERR_W         = DefErrW,
  parameter logic [ERR_W-1:0] SWITCH_THRESH = ERR_W'(DefSwitchThresh),
  parameter logic [ERR_W-1:0] DONE_THRESH   = ERR_W'(DefDoneThresh),
  parameter int unsigned      MAX_ITER      = DefMaxIter,
  parameter int unsigned      ITER_W        = DefIterW
) (
  input logic                  clk,
  input logic                  rst,
  training_control_fsm_if.slave bus
);

  train_state_e state_q, state_d;
  logic         iter_clear;
  logic         iter_enable;
  logic         iter_terminal;

  assign iter_clear  = (state_q == StIdle);
  assign iter_enable = (state_q == StAdam) || (state_q == StManhattan);

  training_iter_counter #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (iter_clear),
    .enable   (iter_enable),
    .terminal (iter_terminal)
  );

  // Abort has top priority; in Manhattan the error target outranks the cap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.training_mode == 1'b1) state_d = StAdam;
      end
      StAdam: begin
        if (!bus.training_mode) begin
          state_d = StIdle;
        end else if (iter_terminal) begin
          state_d = StDone;
        end else if (bus.SQUARED_ERROR < SWITCH_THRESH) begin
          state_d = StManhattan;
        end
      end
      StManhattan: begin
        if (!bus.training_mode) begin
          state_d = StIdle;
        end else if (bus.SQUARED_ERROR <= DONE_THRESH) begin
          state_d = StDone;
        end else if (iter_terminal) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!bus.training_mode) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.adam_signal      = (state_q == StAdam);
  assign bus.manhatten_signal = (state_q == StManhattan);
  assign bus.training_done    = (state_q == StDone);

endmodule

// File: tb/tb_training_control_fsm.sv
// Directed bench for training_control_fsm: an outcome-level model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_training_control_fsm;

  localparam int unsigned ErrW    = 34;
  localparam int unsigned MaxIter = 1000;
  localparam logic [ErrW-1:0] AllOnes = {ErrW{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  training_control_fsm_if #(.ERR_W(ErrW)) bus ();

  training_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: expected flags and number of cycles spent training since the last start.
  logic exp_done = 1'b0;
  logic exp_adam = 1'b0;
  logic exp_man  = 1'b0;
  int   cycles   = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_done <= 1'b0; exp_adam <= 1'b0; exp_man <= 1'b0; cycles <= 0;
    end else if (bus.training_mode !== 1'b1) begin
      exp_done <= 1'b0; exp_adam <= 1'b0; exp_man <= 1'b0; cycles <= 0;
    end else if (exp_done) begin
      exp_done <= 1'b1;
    end else if (!exp_adam && !exp_man) begin
      exp_adam <= 1'b1;
      cycles   <= 0;
    end else begin
      cycles <= cycles + 1;
      if (exp_adam) begin
        if (cycles == MaxIter - 1) begin
          exp_adam <= 1'b0; exp_done <= 1'b1;
        end else if (bus.SQUARED_ERROR < 34'd1024) begin
          exp_adam <= 1'b0; exp_man <= 1'b1;
        end
      end else if (bus.SQUARED_ERROR <= 34'd4 || cycles == MaxIter - 1) begin
        exp_man <= 1'b0; exp_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    checks = checks + 1;
    if ({bus.training_done, bus.adam_signal, bus.manhatten_signal} !==
        {exp_done, exp_adam, exp_man}) begin
      errors = errors + 1;
      $display("FAIL model_cmp t=%0t got done/adam/man=%b%b%b want %b%b%b", $time,
               bus.training_done, bus.adam_signal, bus.manhatten_signal,
               exp_done, exp_adam, exp_man);
    end
    checks = checks + 1;
    if (int'(bus.training_done) + int'(bus.adam_signal) + int'(bus.manhatten_signal) > 1) begin
      errors = errors + 1;
      $display("FAIL one_hot t=%0t got %b%b%b want at most one high", $time,
               bus.training_done, bus.adam_signal, bus.manhatten_signal);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic mode, input logic [ErrW-1:0] err);
    bus.training_mode = mode;
    bus.SQUARED_ERROR = err;
  endtask

  // exp is {training_done, adam_signal, manhatten_signal}
  task automatic check_lit(input string name, input logic [2:0] exp);
    logic [2:0] got;
    got = {bus.training_done, bus.adam_signal, bus.manhatten_signal};
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got done/adam/man=%b want %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  // Holds the current inputs until done rises; counts cycles with each optimiser active.
  task automatic run_to_done(input string name, output int n_adam, output int n_man);
    int budget;
    n_adam = 0;
    n_man  = 0;
    budget = 0;
    while (!bus.training_done && budget < MaxIter + 50) begin
      step();
      if (bus.adam_signal) n_adam++;
      if (bus.manhatten_signal) n_man++;
      budget++;
    end
    checks = checks + 1;
    if (!bus.training_done) begin
      errors = errors + 1;
      $display("FAIL %s_timeout got done=0 want done=1 within %0d cycles", name, budget);
    end
  endtask

  int na, nm;

  initial begin
    drive(1'b0, '0);
    #12;
    check_lit("reset_state", 3'b000);

    // 1. Reset
    step(); rst = 1'b1;
    step(); check_lit("idle_after_release", 3'b000);
    step(); check_lit("idle_mode0", 3'b000);
    drive(1'b1, AllOnes);
    step(); check_lit("rst_enter_adam", 3'b010);
    step();
    #2 rst = 1'b0;
    #1 check_lit("async_reset", 3'b000);
    step(); rst = 1'b1; drive(1'b0, AllOnes);
    step(); check_lit("idle_after_reset", 3'b000);

    // 2. Fast convergence
    drive(1'b1, 34'd3);
    step(); check_lit("fast_adam", 3'b010);
    step(); check_lit("fast_manhattan", 3'b001);
    step(); check_lit("fast_done", 3'b100);
    step(); check_lit("done_held", 3'b100);
    drive(1'b0, 34'd3);
    step(); check_lit("done_drop", 3'b000);

    // 3. Abort
    drive(1'b1, AllOnes);
    for (int i = 0; i < 5; i++) begin
      step(); check_lit("abort_adam_held", 3'b010);
    end
    drive(1'b0, AllOnes);
    step(); check_lit("abort_idle", 3'b000);
    drive(1'b0, 34'd3);
    step(); check_lit("abort_idle_err3", 3'b000);

    // 4. Thresholds
    drive(1'b1, 34'd1024);
    step(); check_lit("thr_enter_adam", 3'b010);
    step(); check_lit("thr_1024_stays", 3'b010);
    drive(1'b1, 34'd1023);
    step(); check_lit("thr_1023_switch", 3'b001);
    drive(1'b1, AllOnes);
    step(); check_lit("thr_no_return", 3'b001);
    drive(1'b1, 34'd5);
    step(); check_lit("thr_5_stays", 3'b001);
    drive(1'b1, 34'd4);
    step(); check_lit("thr_4_done", 3'b100);
    drive(1'b0, 34'd4);
    step(); check_lit("thr_exit", 3'b000);

    // Abort from Manhattan
    drive(1'b1, 34'd100);
    step(); step(); check_lit("man_abort_pre", 3'b001);
    drive(1'b0, 34'd100);
    step(); check_lit("man_abort", 3'b000);

    // 5. Iteration cap in Adam
    drive(1'b1, AllOnes);
    run_to_done("cap_adam", na, nm);
    check_int("cap_adam_cycles", na, MaxIter);
    check_int("cap_adam_man_cycles", nm, 0);
    drive(1'b0, AllOnes);
    step(); check_lit("cap_exit", 3'b000);

    // Cap reached in Manhattan: one Adam cycle, then Manhattan to the cap
    drive(1'b1, 34'd100);
    run_to_done("cap_man", na, nm);
    check_int("cap_man_adam_cycles", na, 1);
    check_int("cap_man_man_cycles", nm, MaxIter - 1);
    drive(1'b0, 34'd100);
    step();

    // 6. Restart
    drive(1'b1, 34'd0);
    step(); step(); step(); check_lit("rs_done", 3'b100);
    drive(1'b0, 34'd0);
    step(); check_lit("rs_idle", 3'b000);
    drive(1'b1, 34'd0);
    step(); check_lit("rs_adam_first", 3'b010);
    step(); check_lit("rs_manhattan", 3'b001);
    step(); check_lit("rs_done_again", 3'b100);
    drive(1'b0, 34'd0);
    step();
    // A partial run followed by an abort must not shorten the next run.
    drive(1'b1, AllOnes);
    for (int i = 0; i < 500; i++) step();
    check_lit("rs_partial_adam", 3'b010);
    drive(1'b0, AllOnes);
    step();
    drive(1'b1, AllOnes);
    run_to_done("rs_full", na, nm);
    check_int("rs_full_adam_cycles", na, MaxIter);
    drive(1'b0, AllOnes);
    step(); check_lit("final_idle", 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/training_control_fsm.md
Name: training_control_fsm

Overview:
- Training-phase controller for the NN accelerator's training loop.
- Watches the training request (training_mode) and the current squared error from the error datapath.
- Selects the optimiser: Adam for coarse descent, then Manhattan (sign-based) update for fine tuning.
- Flags training_done when the error target or the iteration cap is reached.

Parameters:
ERR_W, 34, width of SQUARED_ERROR (unsigned)
SWITCH_THRESH, 34'd1024, error strictly below this moves Adam -> Manhattan
DONE_THRESH, 34'd4, error less than or equal to this in Manhattan -> done
MAX_ITER, 1000, max cycles spent in ADAM+MANHATTAN before forced done
ITER_W, 16, iteration counter width (must satisfy MAX_ITER < 2**ITER_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
training_mode  input  1  1 = training requested/enabled; 0 = abort/idle
SQUARED_ERROR  input  ERR_W  current squared error, unsigned
training_done  output  1  training finished (target met or iteration cap)
adam_signal  output  1  Adam optimiser update enable
manhatten_signal  output  1  Manhattan optimiser update enable

Behaviour:
- Reset and interface: one clock; reset asynchronous, active-low on rst.
- While rst=0: state=IDLE, iteration counter=0, all outputs 0.
- Moore machine. Outputs are decoded from the registered state only, never directly from inputs.
- Outputs are one-hot or all-zero; at most one is high in any cycle.
- Inputs are sampled on the rising clk edge; the response is visible after that edge (1-cycle latency).
- All error comparisons are unsigned, full ERR_W width.
- States (2-bit encoding): IDLE=0, ADAM=1, MANHATTAN=2, DONE=3.
- IDLE: outputs all 0; counter cleared.
  - training_mode=1 -> ADAM, regardless of SQUARED_ERROR.
  - Otherwise stay in IDLE.
- ADAM: adam_signal=1; counter increments each cycle. Priority order:
  - training_mode=0 -> IDLE.
  - counter == MAX_ITER-1 -> DONE.
  - SQUARED_ERROR < SWITCH_THRESH -> MANHATTAN.
  - Otherwise stay in ADAM.
- MANHATTAN: manhatten_signal=1; counter keeps incrementing. Priority order:
  - training_mode=0 -> IDLE.
  - SQUARED_ERROR <= DONE_THRESH -> DONE.
  - counter == MAX_ITER-1 -> DONE.
  - Otherwise stay. There is no return to ADAM, even if the error rises.
- DONE: training_done=1; counter frozen.
  - Stay while training_mode=1.
  - training_mode=0 -> IDLE (one cycle later training_done=0).
- Boundary conditions:
  - Error exactly equal to SWITCH_THRESH does not switch.
  - Error exactly equal to DONE_THRESH finishes.
  - All-ones error never switches or finishes; only the iteration cap can end training.
  - Abort (training_mode=0) has top priority in every active state.
  - Reassertion of training_mode after IDLE restarts from ADAM with the counter at 0.
  - Reset mid-operation returns to IDLE immediately (asynchronously).
  - X/undefined training_mode in IDLE is treated as not-1; stay in IDLE.
- Illegal or unreached encodings are not possible with 2 bits. The default branch of the next-state logic -> IDLE.

Decomposition:
- Shared package: state enum (IDLE, ADAM, MANHATTAN, DONE) and default threshold constants, for reuse by the optimiser datapath and debug.
- Natural sub-module: training_iter_counter. It provides clear, enable and terminal-count flag (count == MAX_ITER-1).
- FSM next-state/output logic stays in the top module.

Test Plan:
1. Reset: drive rst=0 mid-ADAM -> outputs immediately 000, state IDLE; release, training_mode=0 -> stays 000.
2. Fast convergence: mode=1, err=3 → next edge adam=1; following edge manhatten=1 (3<1024); next edge training_done=1 (3<=4); then mode=0 → done drops the following edge.
3. Abort: mode=1, err=34'h3FFFFFFFF → adam=1 held for several cycles; mode=0 → all outputs 0 next edge; mode=0 with err=3 keeps 000.
4. Thresholds: err=1024 in ADAM stays ADAM; err=1023 → MANHATTAN; err=5 stays MANHATTAN; err=4 → DONE.
5. Iteration cap: mode=1, err all-ones held → adam=1 for exactly MAX_ITER cycles, then training_done=1; check adam/manhatten never high together.
6. Restart: from DONE, mode=0 one cycle then mode=1 with err=0 → ADAM (not DONE) first, counter restarts from 0.
